phase_sequencer: RTL and testbench

Parametrised multi-phase pulse sequencer: a start request walks a one-hot output vector through NPH phases, each held for its own programmable number of clock cycles, then returns to idle or loops. It is the generalised successor of the fixed three-phase, three-cycles-per-phase sequencer. It adds per-phase durations, zero-length phase skipping, repeat mode, abort, asynchronous reset and status outputs. It drives downstream enables such as ADC/PCM sampling strobes or multiplexer selects.

---
 rtl/phase_sequencer.sv | 123 ++++++++++++
 tb/tb_phase_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Multi-phase pulse sequencer: walks a one-hot output through NPH phases,
// each held for its own snapshotted duration, with skip, repeat and abort.
module phase_sequencer #(
    parameter  int NPH = 3,
    parameter  int CW  = 4,
    localparam int PW  = (NPH > 2) ? $clog2(NPH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set,
    input  logic              abort,
    input  logic              repeat_en,
    input  logic [NPH*CW-1:0] dur,
    output logic [NPH-1:0]    q,
    output logic [PW-1:0]     phase,
    output logic              busy,
    output logic              done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic [NPH-1:0]     q_n;
    logic [PW-1:0]      phase_n;
    logic               busy_n, done_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [NPH*CW-1:0]  snap, snap_n;
    logic [PW:0]        hit_set, hit_next, hit_wrap;

    // Lowest phase index >= start with a nonzero duration; MSB flags a hit.
    function automatic logic [PW:0] find_phase(input logic [NPH*CW-1:0] d, input int start);
        logic [PW:0] r;
        r = '0;
        for (int i = NPH - 1; i >= 0; i--) begin
            if (i >= start && d[i*CW +: CW] != '0) r = {1'b1, PW'(i)};
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] field(input logic [NPH*CW-1:0] d, input logic [PW-1:0] idx);
        return d[idx*CW +: CW];
    endfunction

    assign hit_set  = find_phase(dur, 0);
    assign hit_next = find_phase(snap, int'(phase) + 1);
    assign hit_wrap = find_phase(snap, 0);

    always_comb begin
        state_n = state;
        q_n     = q;
        phase_n = phase;
        busy_n  = busy;
        done_n  = 1'b0;
        cnt_n   = cnt;
        snap_n  = snap;
        if (abort) begin
            state_n = IDLE;
            q_n     = '0;
            phase_n = '0;
            busy_n  = 1'b0;
            cnt_n   = '0;
        end else if (set) begin
            snap_n = dur;
            if (hit_set[PW]) begin
                state_n = RUN;
                phase_n = hit_set[PW-1:0];
                q_n     = NPH'(1) << hit_set[PW-1:0];
                busy_n  = 1'b1;
                cnt_n   = field(dur, hit_set[PW-1:0]);
            end else begin
                // Nothing to run: report an empty completed pass.
                state_n = IDLE;
                q_n     = '0;
                phase_n = '0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                cnt_n   = '0;
            end
        end else if (state == RUN) begin
            if (cnt > CW'(1)) begin
                cnt_n = cnt - CW'(1);
            end else if (hit_next[PW]) begin
                phase_n = hit_next[PW-1:0];
                q_n     = NPH'(1) << hit_next[PW-1:0];
                cnt_n   = field(snap, hit_next[PW-1:0]);
            end else if (repeat_en) begin
                // A running pass guarantees the snapshot has a nonzero phase.
                done_n  = 1'b1;
                phase_n = hit_wrap[PW-1:0];
                q_n     = NPH'(1) << hit_wrap[PW-1:0];
                cnt_n   = field(snap, hit_wrap[PW-1:0]);
            end else begin
                done_n  = 1'b1;
                state_n = IDLE;
                q_n     = '0;
                phase_n = '0;
                busy_n  = 1'b0;
                cnt_n   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            phase <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            snap  <= '0;
        end else begin
            state <= state_n;
            q     <= q_n;
            phase <= phase_n;
            busy  <= busy_n;
            done  <= done_n;
            cnt   <= cnt_n;
            snap  <= snap_n;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: expected {busy,done,phase,q} per cycle is built
// from the programmed durations and popped after every rising edge.
module tb_phase_sequencer;

    localparam int NPH = 3;
    localparam int CW  = 4;
    localparam int PW  = 2;
    localparam int W   = 2 + PW + NPH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              set = 1'b0;
    logic              abort = 1'b0;
    logic              repeat_en = 1'b0;
    logic [NPH*CW-1:0] dur = '0;
    logic [NPH-1:0]    q;
    logic [PW-1:0]     phase;
    logic              busy;
    logic              done;
    logic [W-1:0]      obs;
    logic [W-1:0]      exp_q[$];
    int                vectors = 0;
    int                miscompares = 0;

    assign obs = {busy, done, phase, q};

    phase_sequencer #(.NPH(NPH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .set(set), .abort(abort), .repeat_en(repeat_en),
        .dur(dur), .q(q), .phase(phase), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic push_entry(input logic b, input logic dn, input int ph);
        logic [NPH-1:0] qq;
        qq = b ? (3'b001 << ph) : 3'b000;
        exp_q.push_back({b, dn, 2'(ph), qq});
    endtask

    // One pass of phases; zero durations contribute no cycles.
    task automatic push_pass(input int d0, input int d1, input int d2, input logic first_done);
        int   d[3];
        logic fd;
        d[0] = d0; d[1] = d1; d[2] = d2;
        fd = first_done;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < d[p]; c++) begin
                push_entry(1'b1, fd, p);
                fd = 1'b0;
            end
        end
    endtask

    task automatic push_end();
        push_entry(1'b0, 1'b1, 0);
        push_entry(1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        set = 1'b1;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_initial got=%b want=%b", obs, {W{1'b0}});
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_held_set got=%b want=%b", obs, {W{1'b0}});
        end
        set = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_release got=%b want=%b", obs, {W{1'b0}});
        end
    endtask

    task automatic test_legacy();
        logic [W-1:0] e;
        int cyc = 0;
        dur = {4'd3, 4'd3, 4'd3};
        repeat_en = 1'b0;
        push_pass(3, 3, 3, 1'b0);
        push_end();
        set = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            set = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL legacy cyc=%0d got=%b want=%b", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_skip();
        logic [W-1:0] e;
        int cyc = 0;
        dur = {4'd4, 4'd0, 4'd2};
        push_pass(2, 0, 4, 1'b0);
        push_end();
        set = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            set = 1'b0;
            if (cyc == 0) dur = '0;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL skip cyc=%0d got=%b want=%b", cyc, obs, e);
            end
            cyc++;
        end
        // All-zero durations: a lone done pulse, q stays 0.
        push_end();
        set = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            set = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL all_zero cyc=%0d got=%b want=%b", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_repeat();
        logic [W-1:0] e;
        int cyc = 0;
        dur = {4'd1, 4'd1, 4'd1};
        repeat_en = 1'b1;
        push_pass(1, 1, 1, 1'b0);
        push_pass(1, 1, 1, 1'b1);
        push_pass(1, 1, 1, 1'b1);
        push_end();
        set = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            set = 1'b0;
            if (cyc == 7) repeat_en = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL repeat cyc=%0d got=%b want=%b", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_retrigger();
        logic [W-1:0] e;
        int cyc = 0;
        dur = {4'd3, 4'd3, 4'd3};
        repeat (3) push_entry(1'b1, 1'b0, 0);
        push_entry(1'b1, 1'b0, 1);
        push_pass(5, 5, 5, 1'b0);
        push_end();
        set = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            set = (cyc == 3);
            if (cyc == 1) dur = {4'd5, 4'd5, 4'd5};
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL retrigger cyc=%0d got=%b want=%b", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        int cyc = 0;
        dur = {4'd1, 4'd2, 4'd1};
        push_pass(1, 2, 1, 1'b0);
        push_pass(1, 2, 1, 1'b0);
        push_end();
        set = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            set = (cyc == 3);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL back_to_back cyc=%0d got=%b want=%b", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] e;
        int cyc = 0;
        dur = {4'd3, 4'd3, 4'd3};
        repeat (3) push_entry(1'b1, 1'b0, 0);
        push_entry(1'b1, 1'b0, 1);
        push_entry(1'b0, 1'b0, 0);
        push_entry(1'b0, 1'b0, 0);
        set = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            set   = (cyc == 3);
            abort = (cyc == 3);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL abort cyc=%0d got=%b want=%b", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] e;
        int cyc = 0;
        dur = {4'd3, 4'd3, 4'd3};
        push_pass(3, 3, 3, 1'b0);
        set = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            set = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL async_pre cyc=%0d got=%b want=%b", cyc, obs, e);
            end
            if (cyc == 6) break;
            cyc++;
        end
        exp_q.delete();
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL async_reset_immediate got=%b want=%b", obs, {W{1'b0}});
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL async_after_release cyc=%0d got=%b want=%b", i, obs, {W{1'b0}});
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        int d[3];
        int cyc;
        repeat_en = 1'b0;
        for (int t = 0; t < 6; t++) begin
            for (int p = 0; p < 3; p++)
                d[p] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            dur = {4'(d[2]), 4'(d[1]), 4'(d[0])};
            push_pass(d[0], d[1], d[2], 1'b0);
            push_end();
            set = 1'b1;
            cyc = 0;
            while (exp_q.size() > 0) begin
                @(posedge clk);
                #1;
                set = 1'b0;
                dur = 12'($urandom_range(0, 4095));
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL random t=%0d cyc=%0d got=%b want=%b", t, cyc, obs, e);
                end
                cyc++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_skip();
        test_repeat();
        test_retrigger();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
